interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Prioritised interrupt arbiter sitting upstream of program memory's PC_new multiplexer and beside the control unit. Combines the joint TIFR and TIMSK buses with the SREG I bit, and requests a vector fetch at instruction boundaries. On acceptance, it clears the serviced TIFR flag and the I bit. It re-enables I on RETI with AVR one-instruction-after-RETI semantics.

## Interface
- VECTOR_BASE, 14'h008, word address of the highest-priority source (TIFR bit 7).
- VECTOR_STRIDE, 2, word spacing between consecutive vectors.
- clk  in  1  system clock (sysClock).
- rst  in  1  reset: synchronous, active-high.
- tifr  in  8  joint TIFR flags (bit7 OCF2 … bit0 TOV0).
- timsk  in  8  joint TIMSK enables, bit-aligned with tifr.
- sreg_i  in  1  SREG bit 7 (global interrupt enable).
- instr_boundary  in  1  one-cycle pulse from the control unit when an instruction completes.
- irq_ack  in  1  control unit has loaded irq_vector into the PC and pushed the return address.
- reti  in  1  one-cycle pulse coincident with the instr_boundary that ends a RETI.
- irq_req  out  1  registered interrupt request to the control unit.
- irq_vector  out  14  registered vector for the PC_new multiplexer.
- tifr_clear  out  8  one-hot, one-cycle flag-clear strobe to the timers.
- sreg_i_clear  out  1  one-cycle strobe: clear SREG I.
- sreg_i_set  out  1  one-cycle strobe: set SREG I.
- in_service  out  1  high while an ISR is executing.

## Operation
- eligible = tifr & timsk & {8{sreg_i}}.
- Priority is highest bit first; winner index k.
- vector = VECTOR_BASE + (7-k)*VECTOR_STRIDE, computed in 14 bits. Defaults give bit7→0x008 through bit4→0x00E and bit0→0x016.
- States:
  - IDLE: on instr_boundary with eligible≠0 → PENDING, latching winner k and its vector. Otherwise stay.
  - PENDING: irq_req=1. Re-arbitrate every cycle; the latched k and vector follow the current highest eligible source. If eligible becomes 0 with no irq_ack → IDLE (request withdrawn, no strobes). On irq_ack → SERVICE, with tifr_clear[k]=1 and sreg_i_clear=1 for one cycle.
  - SERVICE: in_service=1, irq_req=0. Ignore instr_boundary and eligible. On reti → HOLD, with sreg_i_set=1 for one cycle.
  - HOLD: one instruction must execute after RETI. The next instr_boundary is evaluated as in IDLE (→ PENDING if eligible≠0, else → IDLE).
- irq_ack outside PENDING is ignored. reti outside SERVICE is ignored.
- Nested interrupts are not supported. sreg_i set by software inside an ISR has no effect until RETI.

## Timing
- Reset values: state IDLE; irq_req=0, irq_vector=14'h000, tifr_clear=0, sreg_i_clear=0, sreg_i_set=0, in_service=0.
- rst asserted in any state returns the block to IDLE on the next edge and suppresses any strobe due that cycle.
- instr_boundary at edge N with eligible≠0 gives irq_req=1 and a valid irq_vector at N+1.
- irq_ack sampled at edge M (PENDING):
  - M+1: irq_req=0, in_service=1, tifr_clear[k] and sreg_i_clear high.
  - M+2: strobes low.
- k is the value latched at M. If irq_ack coincides with a withdrawal, irq_ack wins.
- reti at edge R (SERVICE):
  - R+1: sreg_i_set high, in_service=0.
  - R+2: sreg_i_set low.
- Minimum latency from reti to a new irq_req is the next instr_boundary plus one cycle.
- A flag arriving without an instr_boundary in IDLE does not raise irq_req until the next boundary.

## Test plan
- Single source: tifr=0x10, timsk=0x10, sreg_i=1, instr_boundary pulse → irq_req=1, irq_vector=0x00E next cycle. irq_ack → tifr_clear=0x10, sreg_i_clear pulse, in_service=1.
- Priority: tifr=0x11, timsk=0xFF → vector 0x00E. After ack and RETI, with tifr=0x01 remaining → vector 0x016.
- Masking: tifr=0xFF with timsk=0x00, or with sreg_i=0, over 10 boundaries → irq_req stays 0.
- Withdrawal and retarget:
  - In PENDING on bit0, set tifr bit 7 → irq_vector becomes 0x008 the next cycle.
  - Clear all flags with no ack → IDLE, no strobes.
- RETI hold: pending flag during SERVICE; reti → sreg_i_set pulse. No irq_req until the first instr_boundary after RETI, then irq_req=1.
- Reset mid-operation: assert rst in PENDING and in SERVICE → all outputs 0 next cycle. Stray irq_ack or reti in IDLE → no strobes.

Source files
------------

// File: rtl/interrupt_controller.sv
// Prioritised interrupt arbiter: picks the highest enabled TIFR flag at an
// instruction boundary, requests a vector fetch and sequences SREG I handling.
module interrupt_controller #(
  parameter logic [13:0] VECTOR_BASE   = 14'h008,
  parameter int unsigned VECTOR_STRIDE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tifr,
  input  logic [7:0]  timsk,
  input  logic        sreg_i,
  input  logic        instr_boundary,
  input  logic        irq_ack,
  input  logic        reti,
  output logic        irq_req,
  output logic [13:0] irq_vector,
  output logic [7:0]  tifr_clear,
  output logic        sreg_i_clear,
  output logic        sreg_i_set,
  output logic        in_service
);

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE, HOLD} state_t;

  state_t      state, state_nx;
  logic [7:0]  eligible;
  logic        any_eligible;
  logic [2:0]  win_k;
  logic [13:0] win_rank;
  logic [13:0] win_vec;
  logic [2:0]  k_q, k_nx;
  logic [13:0] vec_nx;
  logic [7:0]  clear_nx;
  logic        iclr_nx, iset_nx;

  assign eligible     = tifr & timsk & {8{sreg_i}};
  assign any_eligible = |eligible;

  // Ascending scan: the last set bit seen is the highest-priority one.
  always_comb begin
    win_k = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (eligible[i]) win_k = i[2:0];
    end
  end

  assign win_rank = 14'(3'd7 - win_k);
  assign win_vec  = VECTOR_BASE + win_rank * 14'(VECTOR_STRIDE);

  always_comb begin
    state_nx = state;
    k_nx     = k_q;
    vec_nx   = irq_vector;
    clear_nx = '0;
    iclr_nx  = 1'b0;
    iset_nx  = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (instr_boundary) begin
          if (any_eligible) begin
            state_nx = PENDING;
            k_nx     = win_k;
            vec_nx   = win_vec;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      PENDING: begin
        // Acknowledge beats a simultaneous withdrawal; the clear uses the
        // source already presented to the control unit.
        if (irq_ack) begin
          state_nx = SERVICE;
          clear_nx = 8'b1 << k_q;
          iclr_nx  = 1'b1;
        end else if (!any_eligible) begin
          state_nx = IDLE;
        end else begin
          k_nx   = win_k;
          vec_nx = win_vec;
        end
      end
      SERVICE: begin
        if (reti) begin
          state_nx = HOLD;
          iset_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k_q          <= '0;
      irq_vector   <= '0;
      tifr_clear   <= '0;
      sreg_i_clear <= 1'b0;
      sreg_i_set   <= 1'b0;
    end else begin
      state        <= state_nx;
      k_q          <= k_nx;
      irq_vector   <= vec_nx;
      tifr_clear   <= clear_nx;
      sreg_i_clear <= iclr_nx;
      sreg_i_set   <= iset_nx;
    end
  end

  assign irq_req    = (state == PENDING);
  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: stimulus queues each expected change of the output set;
// a monitor compares every observed change against the queue in order.
module tb_interrupt_controller;

  typedef struct packed {
    logic        rq;
    logic [13:0] vec;
    logic [7:0]  tc;
    logic        sc;
    logic        ss;
    logic        ins;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tifr = '0;
  logic [7:0]  timsk = '0;
  logic        sreg_i = 1'b0;
  logic        instr_boundary = 1'b0;
  logic        irq_ack = 1'b0;
  logic        reti = 1'b0;
  logic        irq_req;
  logic [13:0] irq_vector;
  logic [7:0]  tifr_clear;
  logic        sreg_i_clear;
  logic        sreg_i_set;
  logic        in_service;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  interrupt_controller #(.VECTOR_BASE(14'h008), .VECTOR_STRIDE(2)) dut (
    .clk(clk), .rst(rst), .tifr(tifr), .timsk(timsk), .sreg_i(sreg_i),
    .instr_boundary(instr_boundary), .irq_ack(irq_ack), .reti(reti),
    .irq_req(irq_req), .irq_vector(irq_vector), .tifr_clear(tifr_clear),
    .sreg_i_clear(sreg_i_clear), .sreg_i_set(sreg_i_set), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_rec(input logic rq, input logic [13:0] vec, input logic [7:0] tc,
                            input logic sc, input logic ss, input logic ins);
    rec_t r;
    r.rq = rq; r.vec = vec; r.tc = tc; r.sc = sc; r.ss = ss; r.ins = ins;
    exp_q.push_back(r);
  endtask

  task automatic boundary();
    instr_boundary = 1'b1;
    cyc();
    instr_boundary = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    instr_boundary = 1'b1;
    cyc();
    reti = 1'b0;
    instr_boundary = 1'b0;
  endtask

  // Monitor: every change of the sampled output set is one DUT event.
  initial begin : monitor
    rec_t cur, prev, want;
    bit   have_prev;
    int   ev;
    have_prev = 0;
    ev = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {irq_req, irq_vector, tifr_clear, sreg_i_clear, sreg_i_set, in_service};
        if (!have_prev || cur != prev) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event_%0d unexpected: got rq=%b vec=%h tc=%h sc=%b ss=%b is=%b, none expected",
                     ev, cur.rq, cur.vec, cur.tc, cur.sc, cur.ss, cur.ins);
          end else begin
            want = exp_q.pop_front();
            if (cur != want) begin
              n_bad++;
              $display("FAIL event_%0d: got rq=%b vec=%h tc=%h sc=%b ss=%b is=%b, want rq=%b vec=%h tc=%h sc=%b ss=%b is=%b",
                       ev, cur.rq, cur.vec, cur.tc, cur.sc, cur.ss, cur.ins,
                       want.rq, want.vec, want.tc, want.sc, want.ss, want.ins);
            end
          end
          ev++;
          prev = cur;
          have_prev = 1;
        end
      end
    end
  end

  initial begin : stim
    cyc(3);
    rst = 1'b0;
    expect_rec(0, 14'h000, 8'h00, 0, 0, 0);
    mon_en = 1'b1;
    cyc(2);

    // Single source, bit 4
    tifr = 8'h10; timsk = 8'h10; sreg_i = 1'b1;
    expect_rec(1, 14'h00E, 8'h00, 0, 0, 0);
    boundary();
    cyc(2);
    expect_rec(0, 14'h00E, 8'h10, 1, 0, 1);
    expect_rec(0, 14'h00E, 8'h00, 0, 0, 1);
    ack();
    tifr = 8'h00; sreg_i = 1'b0;
    cyc(3);
    expect_rec(0, 14'h00E, 8'h00, 0, 1, 0);
    expect_rec(0, 14'h00E, 8'h00, 0, 0, 0);
    do_reti();
    sreg_i = 1'b1;
    cyc(2);
    boundary();
    cyc(2);

    // Priority: bits 4 and 0; bit 0 serviced after RETI, not before the next boundary
    tifr = 8'h11; timsk = 8'hFF;
    expect_rec(1, 14'h00E, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(0, 14'h00E, 8'h10, 1, 0, 1);
    expect_rec(0, 14'h00E, 8'h00, 0, 0, 1);
    ack();
    tifr = 8'h01; sreg_i = 1'b0;
    cyc(3);
    expect_rec(0, 14'h00E, 8'h00, 0, 1, 0);
    expect_rec(0, 14'h00E, 8'h00, 0, 0, 0);
    do_reti();
    sreg_i = 1'b1;
    cyc(4);
    expect_rec(1, 14'h016, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(0, 14'h016, 8'h01, 1, 0, 1);
    expect_rec(0, 14'h016, 8'h00, 0, 0, 1);
    ack();
    tifr = 8'h00; sreg_i = 1'b0;
    cyc(2);
    expect_rec(0, 14'h016, 8'h00, 0, 1, 0);
    expect_rec(0, 14'h016, 8'h00, 0, 0, 0);
    do_reti();
    sreg_i = 1'b1;
    cyc();
    boundary();
    cyc(2);

    // Masking by timsk, then by sreg_i
    tifr = 8'hFF; timsk = 8'h00; sreg_i = 1'b1;
    for (int i = 0; i < 10; i++) begin boundary(); cyc(); end
    timsk = 8'hFF; sreg_i = 1'b0;
    for (int i = 0; i < 10; i++) begin boundary(); cyc(); end

    // Flag present without a boundary, then boundary, then withdrawal
    sreg_i = 1'b1;
    cyc(5);
    expect_rec(1, 14'h008, 8'h00, 0, 0, 0);
    boundary();
    cyc(2);
    expect_rec(0, 14'h008, 8'h00, 0, 0, 0);
    tifr = 8'h00;
    cyc(3);

    // Retarget, then ack coinciding with withdrawal
    tifr = 8'h01;
    expect_rec(1, 14'h016, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(1, 14'h008, 8'h00, 0, 0, 0);
    tifr = 8'h81;
    cyc(2);
    expect_rec(1, 14'h016, 8'h00, 0, 0, 0);
    tifr = 8'h01;
    cyc(2);
    expect_rec(0, 14'h016, 8'h01, 1, 0, 1);
    expect_rec(0, 14'h016, 8'h00, 0, 0, 1);
    tifr = 8'h00;
    ack();
    cyc(2);

    // Reset in SERVICE
    expect_rec(0, 14'h000, 8'h00, 0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc(2);

    // Reset in PENDING, coincident with an ack: no strobes
    tifr = 8'h10;
    expect_rec(1, 14'h00E, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(0, 14'h000, 8'h00, 0, 0, 0);
    rst = 1'b1; irq_ack = 1'b1; tifr = 8'h00;
    cyc();
    rst = 1'b0; irq_ack = 1'b0;
    cyc(2);

    // Stray ack / reti in IDLE
    ack();
    cyc();
    do_reti();
    cyc(3);

    // RETI hold with a new flag raised during SERVICE
    tifr = 8'h04;
    expect_rec(1, 14'h012, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(0, 14'h012, 8'h04, 1, 0, 1);
    expect_rec(0, 14'h012, 8'h00, 0, 0, 1);
    ack();
    tifr = 8'h20; sreg_i = 1'b0;
    cyc(2);
    boundary();
    sreg_i = 1'b1;
    boundary();
    ack();
    cyc(2);
    expect_rec(0, 14'h012, 8'h00, 0, 1, 0);
    expect_rec(0, 14'h012, 8'h00, 0, 0, 0);
    do_reti();
    cyc(3);
    expect_rec(1, 14'h00C, 8'h00, 0, 0, 0);
    boundary();
    cyc();
    expect_rec(0, 14'h00C, 8'h20, 1, 0, 1);
    expect_rec(0, 14'h00C, 8'h00, 0, 0, 1);
    ack();
    tifr = 8'h00;
    cyc(4);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expected events never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
